// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: stage 1 registers operands/opcode, stage 2 computes and
// registers result and flags. valid/ready flow control on both sides.
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       alu_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             overflow,
  output logic             carry,
  output logic             zero,
  output logic             bad_op
);
  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Handshake: a side transfers on the rising edge where its valid and ready are both 1.
  // Stage 2 may take a new op whenever it is empty or its result is leaving this cycle.
  logic             s1_valid_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [4:0]       code_q;
  logic             out_valid_q, ovf_q, carry_q, zero_q, bad_q;
  logic [WIDTH-1:0] c_q;

  logic s2_free, s1_adv, in_fire;
  assign s2_free  = !out_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s2_free;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      code_q     <= '0;
    end else if (in_fire) begin
      s1_valid_q <= 1'b1;
      a_q        <= a;
      b_q        <= b;
      code_q     <= alu_code;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  logic [WIDTH:0]   add_x, sub_x;
  logic [WIDTH-1:0] inc_r, dec_r;
  logic [SHW-1:0]   shamt;
  logic             lt_s, eq;
  assign add_x = {1'b0, a_q} + {1'b0, b_q};
  assign sub_x = {1'b0, a_q} - {1'b0, b_q};   // top bit is the unsigned borrow
  assign inc_r = a_q + ONE;
  assign dec_r = a_q - ONE;
  assign shamt = b_q[SHW-1:0];
  assign lt_s  = $signed(a_q) < $signed(b_q);
  assign eq    = (a_q == b_q);

  logic [WIDTH-1:0] c_d;
  logic             ovf_d, carry_d, zero_d, bad_d;

  always_comb begin
    c_d     = '0;
    ovf_d   = 1'b0;
    carry_d = 1'b0;
    bad_d   = 1'b0;
    case (code_q)
      5'b00000: begin
        c_d   = add_x[WIDTH-1:0];
        ovf_d = (a_q[MSB] == b_q[MSB]) && (add_x[MSB] != a_q[MSB]);
      end
      5'b00001: begin
        c_d     = add_x[WIDTH-1:0];
        carry_d = add_x[WIDTH];
      end
      5'b00010: begin
        c_d   = sub_x[WIDTH-1:0];
        ovf_d = (a_q[MSB] != b_q[MSB]) && (sub_x[MSB] != a_q[MSB]);
      end
      5'b00011: begin
        c_d     = sub_x[WIDTH-1:0];
        carry_d = sub_x[WIDTH];
      end
      5'b00100: begin
        c_d   = inc_r;
        ovf_d = (a_q == MAX_POS);
      end
      5'b00101: begin
        c_d   = dec_r;
        ovf_d = (a_q == MIN_NEG);
      end
      5'b01000: c_d = a_q & b_q;
      5'b01001: c_d = a_q | b_q;
      5'b01010: c_d = a_q ^ b_q;
      5'b01100: c_d = ~a_q;
      5'b10000, 5'b10010: c_d = a_q << shamt;
      5'b10001: c_d = a_q >> shamt;
      5'b10011: c_d = $unsigned($signed(a_q) >>> shamt);
      5'b11000: c_d = {{(WIDTH-1){1'b0}}, lt_s || eq};
      5'b11001: c_d = {{(WIDTH-1){1'b0}}, lt_s};
      5'b11010: c_d = {{(WIDTH-1){1'b0}}, !lt_s};
      5'b11011: c_d = {{(WIDTH-1){1'b0}}, !lt_s && !eq};
      5'b11100: c_d = {{(WIDTH-1){1'b0}}, eq};
      5'b11101: c_d = {{(WIDTH-1){1'b0}}, !eq};
      default:  bad_d = 1'b1;
    endcase
    zero_d = (c_d == '0);
  end

  // Result and flags only change when stage 2 is free, so a stalled output holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      c_q         <= '0;
      ovf_q       <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      bad_q       <= 1'b0;
    end else if (s2_free) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        c_q     <= c_d;
        ovf_q   <= ovf_d;
        carry_q <= carry_d;
        zero_q  <= zero_d;
        bad_q   <= bad_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign overflow  = ovf_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign bad_op    = bad_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vectors with hand-computed results, scoreboard queue
// filled on input accept and drained by an independent output monitor.
module tb_alu_pipe;
  localparam int W  = 16;
  localparam int EW = W + 4;

  logic         clk, rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, c;
  logic [4:0]   alu_code;
  logic         overflow, carry, zero, bad_op;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_code(alu_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .overflow(overflow), .carry(carry), .zero(zero), .bad_op(bad_op)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int checks = 0, fails = 0;
  int n_push = 0, n_out = 0;
  int first_accept = -1, last_accept = -1;
  bit lat_arm = 0;

  function automatic logic [EW-1:0] pack(input logic [W-1:0] rc, input logic ro,
                                         input logic rca, input logic rbad);
    return {rc, ro, rca, (rc == '0), rbad};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, expv);
    end
  endtask

  // driver tasks
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic [4:0] tc, input logic [EW-1:0] texp);
    int budget;
    @(negedge clk);
    a = ta; b = tb; alu_code = tc; in_valid = 1'b1;
    #1;
    budget = 0;
    while (!in_ready && budget < 50) begin
      @(negedge clk); #1;
      budget++;
    end
    if (!in_ready) begin
      checks++; fails++;
      $display("FAIL accept_timeout code=%b", tc);
    end else begin
      exp_q.push_back(texp);
      n_push++;
      last_accept = cyc;
      if (first_accept < 0) first_accept = cyc;
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // monitor: pop on output transfer, check hold while stalled
  always @(negedge clk) begin
    logic [EW-1:0] got, expv;
    #2;
    if (!rst && out_valid) begin
      got = {c, overflow, carry, zero, bad_op};
      if (exp_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_output got=%h", got);
      end else if (out_ready) begin
        expv = exp_q.pop_front();
        n_out++;
        checks++;
        if (got !== expv) begin
          fails++;
          $display("FAIL result got=%h exp=%h", got, expv);
        end
        if (lat_arm) begin
          lat_arm = 0;
          checks++;
          if (cyc - first_accept != 2) begin
            fails++;
            $display("FAIL latency got=%0d exp=2", cyc - first_accept);
          end
        end
      end else begin
        checks++;
        if (got !== exp_q[0]) begin
          fails++;
          $display("FAIL stall_hold got=%h exp=%h", got, exp_q[0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; alu_code = '0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_c", 32'(c), 32'd0);
    chk("rst_flags", 32'({overflow, carry, zero, bad_op}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // directed vectors
    send(16'h8534, 16'h7546, 5'b00000, pack(16'hFA7A, 0, 0, 0));
    send(16'h7FFF, 16'h0001, 5'b00000, pack(16'h8000, 1, 0, 0));
    send(16'h0001, 16'h0002, 5'b00011, pack(16'hFFFF, 0, 1, 0));
    send(16'h8000, 16'h1234, 5'b00101, pack(16'h7FFF, 1, 0, 0));
    send(16'h8000, 16'h7FFF, 5'b11001, pack(16'h0001, 0, 0, 0));
    send(16'h8000, 16'h7FFF, 5'b11011, pack(16'h0000, 0, 0, 0));
    send(16'hAAAA, 16'h2A7B, 5'b10011, pack(16'hFFF5, 0, 0, 0));
    send(16'h1234, 16'h5678, 5'b00111, pack(16'h0000, 0, 0, 1));
    idle(4);
    chk("directed_drained", 32'(exp_q.size()), 32'd0);

    // streaming: 8 back-to-back
    first_accept = -1;
    lat_arm = 1;
    send(16'hF0F0, 16'h3C3C, 5'b01000, pack(16'h3030, 0, 0, 0));
    send(16'hF0F0, 16'h3C3C, 5'b01001, pack(16'hFCFC, 0, 0, 0));
    send(16'hF0F0, 16'h3C3C, 5'b01010, pack(16'hCCCC, 0, 0, 0));
    send(16'hF0F0, 16'h3C3C, 5'b01100, pack(16'h0F0F, 0, 0, 0));
    send(16'hFFFF, 16'h0001, 5'b00001, pack(16'h0000, 0, 1, 0));
    send(16'h7FFF, 16'hFFFF, 5'b00100, pack(16'h8000, 1, 0, 0));
    send(16'h0001, 16'h000F, 5'b10000, pack(16'h8000, 0, 0, 0));
    send(16'h8000, 16'h0004, 5'b10001, pack(16'h0800, 0, 0, 0));
    chk("throughput", 32'(last_accept - first_accept), 32'd7);
    idle(4);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);
    chk("lat_checked", 32'(lat_arm), 32'd0);

    // back-pressure
    @(negedge clk);
    out_ready = 1'b0;
    send(16'h0003, 16'h0001, 5'b10010, pack(16'h0006, 0, 0, 0));
    send(16'h1234, 16'h1234, 5'b11100, pack(16'h0001, 0, 0, 0));
    @(negedge clk);
    a = 16'h1234; b = 16'h1234; alu_code = 5'b11101; in_valid = 1'b1;
    #1;
    repeat (3) begin
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk); #1;
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    send(16'h1234, 16'h1234, 5'b11101, pack(16'h0000, 0, 0, 0));
    send(16'hFFFF, 16'h0000, 5'b11010, pack(16'h0000, 0, 0, 0));
    send(16'hFFFF, 16'h0000, 5'b11000, pack(16'h0001, 0, 0, 0));
    send(16'h8000, 16'h0001, 5'b00010, pack(16'h7FFF, 1, 0, 0));
    send(16'h8000, 16'h8000, 5'b00001, pack(16'h0000, 0, 1, 0));
    idle(5);
    chk("no_loss_dup", 32'(n_out), 32'(n_push));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    // reset with both stages full
    out_ready = 1'b0;
    send(16'h0005, 16'h0003, 5'b00000, pack(16'h0008, 0, 0, 0));
    send(16'h0009, 16'h0003, 5'b00000, pack(16'h000C, 0, 0, 0));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_reset_full", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_c", 32'(c), 32'd0);
    chk("async_rst_flags", 32'({overflow, carry, zero, bad_op}), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    #3;
    chk("no_stale_output", 32'(out_valid), 32'd0);
    chk("in_ready_post_rst", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
